mmv_splitter: RTL and testbench
===============================

# mmv_splitter

Address-decoding splitter connecting one MemoryMapped master with arbitrary read latency to several MemoryMapped slaves. It is the counterpart of the many-masters-to-one-slave arbitrator and sits between a master (CPU, bridge, or an arbitrator output) and a bank of peripheral slaves. Upper address bits select the target slave. Read responses return to the master in issue order, with in-flight reads tracked against a bounded pending limit. Accesses to unmapped addresses complete locally.

## Interface
- AWIDTH, 8: address width.
- DWIDTH, 8: data width.
- SLAVES, 3: number of slave ports (SLAVES > 1).
- RDPENDS, 4: maximum number of outstanding reads (RDPENDS ≥ 1).
- DEFDAT, '0: DWIDTH-bit data returned for unmapped reads.
- Derived: SELW = $clog2(SLAVES). Select field sel = s_addr[AWIDTH-1 -: SELW]. sel ≥ SLAVES means unmapped.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- s_addr  in  AWIDTH  master address.
- s_wreq  in  1  write request.
- s_wdat  in  DWIDTH  write data.
- s_rreq  in  1  read request.
- s_rdat  out  DWIDTH  read data to master.
- s_rval  out  1  read data valid.
- s_busy  out  1  request not accepted this cycle.
- m_addr  out  [SLAVES-1:0][AWIDTH-1:0]  s_addr broadcast to every slave.
- m_wreq  out  [SLAVES-1:0]  per-slave write request.
- m_wdat  out  [SLAVES-1:0][DWIDTH-1:0]  s_wdat broadcast.
- m_rreq  out  [SLAVES-1:0]  per-slave read request.
- m_rdat  in  [SLAVES-1:0][DWIDTH-1:0]  slave read data.
- m_rval  in  [SLAVES-1:0]  slave read valid (no backpressure).
- m_busy  in  [SLAVES-1:0]  slave not ready.

## Operation
- **Handshake.** A request is accepted in a cycle when it is asserted and s_busy = 0. While busy, the master holds s_addr, s_wdat and the request unchanged. The master must not assert s_wreq and s_rreq together; if it does, both are forwarded and the read rules govern s_busy.
- **State.**
  - cnt: 0..RDPENDS, outstanding reads.
  - tgt: 0..SLAVES, the target of the outstanding reads; the value SLAVES means unmapped.
  - uval: 1 bit, unmapped response pending.
- **Read admission.** read_ok = (cnt < RDPENDS) & (cnt == 0 | tgt == sel_eff), where sel_eff = sel if mapped, else SLAVES. All outstanding reads therefore share one target, so responses are inherently in order.
- **Mapped write.**
  - m_wreq[sel] = s_wreq; all other m_wreq are 0.
  - s_busy = m_busy[sel].
- **Unmapped write.** Dropped. s_busy = 0, no slave strobed.
- **Mapped read.**
  - m_rreq[sel] = s_rreq & read_ok.
  - s_busy = m_busy[sel] | ~read_ok.
- **Unmapped read.** s_busy = ~read_ok. On acceptance uval is set for one cycle.
- **Idle.** s_busy = 0 whenever s_wreq = s_rreq = 0.
- **Accepted read.** cnt increments and tgt loads sel_eff.
- **Response, mapped tgt.**
  - Combinational: s_rval = m_rval[tgt] & (cnt != 0) and s_rdat = m_rdat[tgt].
  - m_rval from a slave other than tgt, or any m_rval while cnt == 0, is ignored, and s_rval stays 0.
- **Response, unmapped tgt.** s_rval = uval and s_rdat = DEFDAT.
- **Counter.** cnt decrements on every s_rval. Simultaneous accept and response leaves cnt unchanged.
- **Reset (reset = 0, asynchronous).** cnt = 0, tgt = 0, uval = 0.
  - Outputs during reset: s_rval = 0, s_busy = 0 when idle, m_wreq = m_rreq = 0 when idle.
  - Responses still in flight at reset are discarded.

## Timing
- Request path is combinational, with zero added latency: m_wreq, m_rreq and s_busy follow the inputs in the same cycle.
- Mapped read data path is combinational: s_rval appears in the same cycle as m_rval[tgt].
- Unmapped read latency is 1 cycle: s_rval is asserted in the cycle after acceptance.
- Back-to-back unmapped reads give s_rval on consecutive cycles.
- **Target switch.** A read to a different target stalls (s_busy = 1) until cnt reaches 0. It can be accepted in the cycle after the last outstanding response. It is not accepted in the same cycle as that response.
- **Full.** When cnt == RDPENDS, reads stall even to the same target. Admission reopens in the cycle after the next s_rval.
- Writes are never blocked by outstanding reads, including writes to other slaves.

## Test plan
All scenarios use AWIDTH=8, SLAVES=3, RDPENDS=4, DEFDAT=8'hEE; sel = s_addr[7:6].

- **Write decode.** Write 8'h41 with data 8'h5A and all slaves ready → m_wreq = 3'b010 for 1 cycle, m_addr[1] = 8'h41, s_busy = 0.
- **Read ordering and switch stall.**
  - Stimulus: two reads to 8'h02 (slave 0), then a read to 8'h81 (slave 2).
  - The slave-2 read shows s_busy = 1 until the second m_rval[0] arrives, and is accepted the cycle after.
  - The rdat sequence is slave0, slave0, slave2.
- **Pending limit.**
  - Stimulus: 5 reads to slave 1 with no m_rval.
  - Required: 4 accepted, the 5th busy.
  - Pulse m_rval[1] → the 5th read is accepted the next cycle.
- **Unmapped access.**
  - Write 8'hC0 → accepted immediately, no m_wreq.
  - Read 8'hC3 → s_rval = 1 with s_rdat = 8'hEE exactly 1 cycle later.
- **Stray and simultaneous events.**
  - m_rval[2] while tgt = 0 → s_rval = 0.
  - Accept and response in the same cycle → cnt unchanged.
  - m_busy[0] = 1 during a slave-0 read → s_busy = 1 and cnt unchanged.
- **Reset mid-operation.**
  - Stimulus: 3 reads outstanding, then reset = 0 asserted asynchronously.
  - Required: cnt = 0 and s_rval = 0 immediately.
  - After release, late m_rval pulses are ignored, and a new read to any slave is accepted at once.

Source files
------------

// File: rtl/mmv_splitter.sv
// mmv_splitter: address-decoding splitter from one memory-mapped master to
// SLAVES memory-mapped slaves. The upper SELW address bits select the slave.
// Read responses return in issue order. Up to RDPENDS reads may be
// outstanding, and all of them must go to the same target. Unmapped accesses
// complete locally: writes are dropped, and reads return DEFDAT one cycle later.
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   s_addr/s_wreq/s_wdat/s_rreq   master request
//   s_rdat/s_rval   read response to the master
//   s_busy          request not accepted this cycle
//   m_addr/m_wdat   broadcast of s_addr/s_wdat to every slave
//   m_wreq/m_rreq   per-slave request strobes
//   m_rdat/m_rval   per-slave read responses (no backpressure)
//   m_busy          per-slave not-ready
module mmv_splitter #(
  parameter int unsigned       AWIDTH  = 8,
  parameter int unsigned       DWIDTH  = 8,
  parameter int unsigned       SLAVES  = 3,
  parameter int unsigned       RDPENDS = 4,
  parameter logic [DWIDTH-1:0] DEFDAT  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [AWIDTH-1:0]              s_addr,
  input  logic                           s_wreq,
  input  logic [DWIDTH-1:0]              s_wdat,
  input  logic                           s_rreq,
  output logic [DWIDTH-1:0]              s_rdat,
  output logic                           s_rval,
  output logic                           s_busy,
  output logic [SLAVES-1:0][AWIDTH-1:0]  m_addr,
  output logic [SLAVES-1:0]              m_wreq,
  output logic [SLAVES-1:0][DWIDTH-1:0]  m_wdat,
  output logic [SLAVES-1:0]              m_rreq,
  input  logic [SLAVES-1:0][DWIDTH-1:0]  m_rdat,
  input  logic [SLAVES-1:0]              m_rval,
  input  logic [SLAVES-1:0]              m_busy
);

  localparam int unsigned SELW = $clog2(SLAVES);
  localparam int unsigned TGTW = $clog2(SLAVES + 1);
  localparam int unsigned CNTW = $clog2(RDPENDS + 1);

  // The target code SLAVES stands for the local unmapped responder.
  localparam logic [TGTW-1:0] TGT_UNMAPPED = TGTW'(SLAVES);
  localparam logic [CNTW-1:0] CNT_MAX      = CNTW'(RDPENDS);

  logic [CNTW-1:0]   cnt;
  logic [TGTW-1:0]   tgt;
  logic              uval;

  logic [SELW-1:0]   sel;
  logic              mapped;
  logic              sel_busy;
  logic [TGTW-1:0]   sel_eff;
  logic              read_ok;
  logic              rd_accept;
  logic              tgt_mapped;
  logic              tgt_rval;
  logic [DWIDTH-1:0] tgt_rdat;

  assign sel = s_addr[AWIDTH-1 -: SELW];

  // Address and write data are broadcast. Only the strobes are decoded.
  assign m_addr = {SLAVES{s_addr}};
  assign m_wdat = {SLAVES{s_wdat}};

  // Decode the select field. A select value of SLAVES or more is unmapped.
  always_comb begin
    mapped   = 1'b0;
    sel_busy = 1'b0;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      if (sel == SELW'(i)) begin
        mapped   = 1'b1;
        sel_busy = m_busy[i];
      end
    end
  end

  assign sel_eff = mapped ? TGTW'(sel) : TGT_UNMAPPED;

  // One shared target keeps responses in order without a reorder buffer.
  assign read_ok = (cnt < CNT_MAX) && ((cnt == '0) || (tgt == sel_eff));

  // Read rules take precedence when both requests are asserted.
  always_comb begin
    s_busy = 1'b0;
    if (s_rreq) begin
      s_busy = sel_busy | ~read_ok;
    end else if (s_wreq) begin
      s_busy = sel_busy;
    end
  end

  // Per-slave strobes. Unmapped selects strobe nothing.
  always_comb begin
    m_wreq = '0;
    m_rreq = '0;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      if (sel == SELW'(i)) begin
        m_wreq[i] = s_wreq;
        m_rreq[i] = s_rreq & read_ok;
      end
    end
  end

  assign rd_accept = s_rreq & ~s_busy;

  // Pick the response of the current target. An unmapped target falls back to DEFDAT.
  always_comb begin
    tgt_mapped = 1'b0;
    tgt_rval   = 1'b0;
    tgt_rdat   = DEFDAT;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      if (tgt == TGTW'(i)) begin
        tgt_mapped = 1'b1;
        tgt_rval   = m_rval[i];
        tgt_rdat   = m_rdat[i];
      end
    end
  end

  // Valids from non-target slaves, or valids arriving with nothing outstanding, are dropped.
  assign s_rval = tgt_mapped ? (tgt_rval & (cnt != '0)) : uval;
  assign s_rdat = tgt_rdat;

  // Outstanding-read tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tgt  <= '0;
      uval <= 1'b0;
    end else begin
      if (rd_accept && !s_rval) begin
        cnt <= cnt + CNTW'(1);
      end else if (!rd_accept && s_rval) begin
        cnt <= cnt - CNTW'(1);
      end
      if (rd_accept) begin
        tgt <= sel_eff;
      end
      uval <= rd_accept & ~mapped;
    end
  end

endmodule

// File: tb/tb_mmv_splitter.sv
// Testbench for mmv_splitter. A reference model holds the outstanding reads
// in a queue of targets and predicts every cycle's handshake and strobes.
// A separate monitor compares the DUT against those predictions, and pops
// expected read data whenever s_rval is seen.
module tb_mmv_splitter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned NS = 3;
  localparam int          RP = 4;
  localparam logic [7:0]  DEF = 8'hEE;

  logic                  clk;
  logic                  reset;
  logic [AW-1:0]         s_addr;
  logic                  s_wreq;
  logic [DW-1:0]         s_wdat;
  logic                  s_rreq;
  logic [DW-1:0]         s_rdat;
  logic                  s_rval;
  logic                  s_busy;
  logic [NS-1:0][AW-1:0] m_addr;
  logic [NS-1:0]         m_wreq;
  logic [NS-1:0][DW-1:0] m_wdat;
  logic [NS-1:0]         m_rreq;
  logic [NS-1:0][DW-1:0] m_rdat;
  logic [NS-1:0]         m_rval;
  logic [NS-1:0]         m_busy;

  typedef struct {
    logic       busy;
    logic       rval;
    logic [2:0] wreq;
    logic [2:0] rreq;
    logic [7:0] addr;
    logic [7:0] wdat;
  } exp_t;

  exp_t       cyc_q[$];   // per-cycle predictions
  logic [7:0] rdat_q[$];  // read data in issue order
  logic [7:0] sdat_q[$];  // data the target slave still has to return
  int         pend_q[$];  // targets of outstanding reads (3 = unmapped)
  int         n_chk;
  int         n_fail;

  mmv_splitter #(
    .AWIDTH (AW),
    .DWIDTH (DW),
    .SLAVES (NS),
    .RDPENDS(RP),
    .DEFDAT (DEF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s_addr(s_addr),
    .s_wreq(s_wreq),
    .s_wdat(s_wdat),
    .s_rreq(s_rreq),
    .s_rdat(s_rdat),
    .s_rval(s_rval),
    .s_busy(s_busy),
    .m_addr(m_addr),
    .m_wreq(m_wreq),
    .m_wdat(m_wdat),
    .m_rreq(m_rreq),
    .m_rdat(m_rdat),
    .m_rval(m_rval),
    .m_busy(m_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h at %0t", nm, act, req, $time);
    end
  endtask

  // One bus cycle: drive inputs, predict outputs, advance the model.
  task automatic cycle(input logic [7:0] addr, input logic wr, input logic rd,
                       input logic [7:0] wdat, input logic [2:0] fire,
                       input logic [2:0] mbusy, input logic do_rst,
                       output logic acc);
    exp_t       e;
    int         sel;
    int         se;
    logic       sb;
    logic       rok;
    logic       resp;
    logic [7:0] d;
    @(negedge clk);
    s_addr = addr;
    s_wreq = wr;
    s_rreq = rd;
    s_wdat = wdat;
    m_busy = mbusy;
    for (int i = 0; i < 3; i++) begin
      m_rval[i] = fire[i];
      m_rdat[i] = 8'($urandom);
      if (fire[i] && pend_q.size() > 0 && pend_q[0] == i)
        m_rdat[i] = sdat_q.pop_front();
    end
    if (do_rst) begin
      #1 reset = 1'b0;
      pend_q.delete();
      sdat_q.delete();
      rdat_q.delete();
    end
    sel = int'(addr[7:6]);
    se  = (sel < 3) ? sel : 3;
    sb  = (sel < 3) ? mbusy[sel] : 1'b0;
    rok = (pend_q.size() < RP) && (pend_q.size() == 0 || pend_q[0] == se);
    resp = 1'b0;
    if (pend_q.size() > 0) begin
      if (pend_q[0] == 3) resp = 1'b1;
      else                resp = fire[pend_q[0]];
    end
    e.busy = rd ? (sb || !rok) : (wr ? sb : 1'b0);
    e.rval = resp;
    e.wreq = (wr && sel < 3) ? 3'(1 << sel) : 3'b000;
    e.rreq = (rd && rok && sel < 3) ? 3'(1 << sel) : 3'b000;
    e.addr = addr;
    e.wdat = wdat;
    cyc_q.push_back(e);
    acc = (wr || rd) && !e.busy;
    if (resp) void'(pend_q.pop_front());
    if (rd && !e.busy) begin
      pend_q.push_back(se);
      if (se == 3) begin
        rdat_q.push_back(DEF);
      end else begin
        d = 8'($urandom);
        sdat_q.push_back(d);
        rdat_q.push_back(d);
      end
    end
    if (do_rst) #3 reset = 1'b1;
  endtask

  task automatic idle(input logic [2:0] fire);
    logic acc;
    cycle(8'($urandom), 1'b0, 1'b0, 8'($urandom), fire, 3'b000, 1'b0, acc);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && pend_q.size() > 0; k++) idle(3'b111);
    idle(3'b000);
  endtask

  // Monitor: per-cycle predictions plus the in-order read data scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("s_busy", 8'(s_busy), 8'(e.busy));
        chk("s_rval", 8'(s_rval), 8'(e.rval));
        chk("m_wreq", 8'(m_wreq), 8'(e.wreq));
        chk("m_rreq", 8'(m_rreq), 8'(e.rreq));
        for (int i = 0; i < 3; i++) begin
          chk("m_addr", m_addr[i], e.addr);
          chk("m_wdat", m_wdat[i], e.wdat);
        end
      end
      if (s_rval === 1'b1) begin
        if (rdat_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL s_rdat: actual response %h, required no response at %0t", s_rdat, $time);
        end else begin
          chk("s_rdat", s_rdat, rdat_q.pop_front());
        end
      end
    end
  end

  initial begin : driver
    logic       acc;
    logic       have;
    logic       w;
    logic       r;
    logic [7:0] a;
    logic [7:0] wd;
    logic [2:0] fire;
    logic [2:0] mb;
    int         lastsel;
    int         k;
    int         s;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    s_addr = '0;
    s_wreq = 1'b0;
    s_wdat = '0;
    s_rreq = 1'b0;
    m_rdat = '0;
    m_rval = '0;
    m_busy = '0;
    #1 reset = 1'b0;

    // Reset state, with stray valids from every slave.
    cycle(8'h00, 1'b0, 1'b0, 8'h00, 3'b111, 3'b000, 1'b1, acc);
    idle(3'b111);

    // Write decode.
    cycle(8'h41, 1'b1, 1'b0, 8'h5A, 3'b000, 3'b000, 1'b0, acc);

    // Read ordering, target-switch stall, and a write that passes outstanding reads.
    cycle(8'h02, 1'b0, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0, acc);
    cycle(8'h02, 1'b0, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0, acc);
    cycle(8'h45, 1'b1, 1'b0, 8'h33, 3'b000, 3'b000, 1'b0, acc);
    cycle(8'h81, 1'b0, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0, acc);
    cycle(8'h81, 1'b0, 1'b1, 8'h00, 3'b001, 3'b000, 1'b0, acc);
    cycle(8'h81, 1'b0, 1'b1, 8'h00, 3'b001, 3'b000, 1'b0, acc);
    cycle(8'h81, 1'b0, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0, acc);
    idle(3'b100);
    drain();

    // Pending limit.
    repeat (6) cycle(8'h41, 1'b0, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0, acc);
    cycle(8'h41, 1'b0, 1'b1, 8'h00, 3'b010, 3'b000, 1'b0, acc);
    cycle(8'h41, 1'b0, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0, acc);
    drain();

    // Unmapped write, single read, and back-to-back reads.
    cycle(8'hC0, 1'b1, 1'b0, 8'h77, 3'b000, 3'b111, 1'b0, acc);
    cycle(8'hC3, 1'b0, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0, acc);
    idle(3'b000);
    repeat (3) cycle(8'hC3, 1'b0, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0, acc);
    idle(3'b000);
    idle(3'b000);

    // Stray valid, accept plus response in one cycle, slave busy.
    cycle(8'h02, 1'b0, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0, acc);
    idle(3'b100);
    cycle(8'h02, 1'b0, 1'b1, 8'h00, 3'b001, 3'b000, 1'b0, acc);
    cycle(8'h02, 1'b0, 1'b1, 8'h00, 3'b000, 3'b001, 1'b0, acc);
    cycle(8'h02, 1'b0, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0, acc);
    cycle(8'h81, 1'b0, 1'b1, 8'h00, 3'b001, 3'b000, 1'b0, acc);
    drain();

    // Reset with three reads outstanding and a response on the wire.
    repeat (3) cycle(8'h41, 1'b0, 1'b1, 8'h00, 3'b000, 3'b000, 1'b0, acc);
    cycle(8'h00, 1'b0, 1'b0, 8'h00, 3'b010, 3'b000, 1'b1, acc);
    cycle(8'h81, 1'b0, 1'b1, 8'h00, 3'b010, 3'b000, 1'b0, acc);
    idle(3'b010);
    drain();

    // Randomized traffic. The master holds each request until it is accepted.
    have    = 1'b0;
    lastsel = 0;
    w = 1'b0; r = 1'b0; a = '0; wd = '0;
    repeat (1500) begin
      if (!have) begin
        k = $urandom_range(0, 9);
        s = ($urandom_range(0, 9) < 6) ? lastsel : $urandom_range(0, 3);
        lastsel = s;
        a  = {2'(s), 6'($urandom)};
        wd = 8'($urandom);
        w  = (k < 3);
        r  = (k >= 3 && k < 8);
        have = w || r;
      end
      for (int i = 0; i < 3; i++) begin
        fire[i] = ($urandom_range(0, 99) < 25);
        mb[i]   = ($urandom_range(0, 99) < 20);
      end
      cycle(a, w, r, wd, fire, mb, 1'b0, acc);
      if (acc || !have) begin
        have = 1'b0;
        w = 1'b0;
        r = 1'b0;
      end
    end
    drain();
    idle(3'b000);
    idle(3'b000);

    @(negedge clk);
    #5;
    chk("rdat_left", 8'(rdat_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
